// File: rtl/sensor_stream_mux.sv
// rtl/sensor_stream_mux.sv - round-robin sensor word mux emitting header + kept bytes as a byte stream
module sensor_stream_mux #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 48,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [CHANNELS-1:0]            s_axis_tvalid,
    output logic [CHANNELS-1:0]            s_axis_tready,
    output logic [7:0]                     m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [15:0]                    frame_count
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t                  state;
    logic [CW-1:0]           last_grant;
    logic [CW-1:0]           grant_idx;
    logic [CW-1:0]           cand_idx;
    logic                    grant_any;
    logic                    accept;
    int                      cand;
    logic [DATA_WIDTH-1:0]   grant_data;
    logic [KEEP_WIDTH-1:0]   grant_keep;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [KEEP_WIDTH-1:0]   rem_keep;
    logic [IW-1:0]           nxt_idx;
    logic                    nxt_found;
    logic [KEEP_WIDTH-1:0]   nxt_rem;
    logic [7:0]              nxt_byte;
    logic                    nxt_last;

    // Round-robin search starting one past the last granted channel
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            cand_idx = CW'(cand);
            if (!grant_any && s_axis_tvalid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Ready only towards the granted channel while idle; reset blocks acceptance
    always_comb begin
        accept        = (state == IDLE) && !reset && grant_any;
        s_axis_tready = '0;
        grant_data    = s_axis_tdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        grant_keep    = s_axis_tkeep[int'(grant_idx)*KEEP_WIDTH +: KEEP_WIDTH];
        if (accept) begin
            s_axis_tready[grant_idx] = 1'b1;
        end
    end

    // Lowest remaining kept byte is the next one to emit; unkept bytes are skipped
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (!nxt_found && rem_keep[i]) begin
                nxt_found = 1'b1;
                nxt_idx   = IW'(i);
            end
        end
        nxt_rem = rem_keep;
        if (nxt_found) begin
            nxt_rem[nxt_idx] = 1'b0;
        end
        nxt_byte = data_r[int'(nxt_idx)*8 +: 8];
        nxt_last = (nxt_rem == '0);
    end

    // Frame FSM with registered output byte, valid and last
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= CW'(CHANNELS - 1);
            data_r        <= '0;
            rem_keep      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_r        <= grant_data;
                        rem_keep      <= grant_keep;
                        last_grant    <= grant_idx;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= {4'(grant_idx), 4'($countones(grant_keep))};
                        m_axis_tlast  <= (grant_keep == '0);
                        state         <= HEADER;
                    end
                end
                HEADER, PAYLOAD: begin
                    if (m_axis_tready) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tdata  <= '0;
                            m_axis_tlast  <= 1'b0;
                            frame_count   <= frame_count + 16'd1;
                            state         <= IDLE;
                        end else begin
                            m_axis_tdata  <= nxt_byte;
                            m_axis_tlast  <= nxt_last;
                            rem_keep      <= nxt_rem;
                            state         <= PAYLOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_stream_mux.sv
// tb/tb_sensor_stream_mux.sv - directed and randomized-ready self-checking bench for sensor_stream_mux
module tb_sensor_stream_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] s_axis_tdata;
    logic [11:0] s_axis_tkeep;
    logic [1:0]  s_axis_tvalid;
    logic [1:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] frame_count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];

    sensor_stream_mux #(.CHANNELS(2), .DATA_WIDTH(48)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; leaves the bench at the negedge showing the header
    task automatic drive_word(input int ch, input logic [47:0] d, input logic [5:0] k);
        logic [1:0] exp_rdy;
        exp_rdy     = '0;
        exp_rdy[ch] = 1'b1;
        s_axis_tdata[ch*48 +: 48] = d;
        s_axis_tkeep[ch*6 +: 6]   = k;
        s_axis_tvalid[ch]         = 1'b1;
        #1;
        check("tready_grant", {30'd0, s_axis_tready}, {30'd0, exp_rdy});
        @(negedge clk);
        s_axis_tvalid = '0;
        check("hdr_valid", {31'd0, m_axis_tvalid}, 32'd1);
    endtask

    task automatic build_expected(input int ch, input logic [47:0] d, input logic [5:0] k);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 6; i++) cnt = cnt + {3'd0, k[i]};
        exp_q.delete();
        exp_q.push_back({4'(ch), cnt});
        for (int i = 0; i < 6; i++) begin
            if (k[i]) exp_q.push_back(d[i*8 +: 8]);
        end
    endtask

    // Collects one frame; returns at the negedge after the tlast handshake
    task automatic collect_frame(input bit rand_ready);
        int         cyc;
        bit         done;
        logic       prev_stall;
        logic [7:0] pd;
        logic       pl;
        got.delete();
        cyc        = 0;
        done       = 0;
        prev_stall = 1'b0;
        pd         = '0;
        pl         = 1'b0;
        while (!done && cyc < 300) begin
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                check("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
                check("stall_data", {24'd0, m_axis_tdata}, {24'd0, pd});
                check("stall_last", {31'd0, m_axis_tlast}, {31'd0, pl});
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                got.push_back(m_axis_tdata);
                if (m_axis_tlast) done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        check("frame_done", {31'd0, done}, 32'd1);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check(tag, {24'd0, got[i]}, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] d;
        logic [5:0]  k;
        int          ch;

        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 2'b11;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tready", {30'd0, s_axis_tready}, 32'd0);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
        check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("rst_fc", {16'd0, frame_count}, 32'd0);
        s_axis_tvalid = '0;
        reset         = 1'b0;

        // Full six-byte frame from channel 0
        drive_word(0, 48'h060504030201, 6'h3F);
        exp_q = '{8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        collect_frame(0);
        compare_frame("f032");
        check("f032_idle", {31'd0, m_axis_tvalid}, 32'd0);
        check("f032_fc", {16'd0, frame_count}, 32'd1);

        // Non-contiguous keep on channel 1
        drive_word(1, 48'h0000_00CC_BBAA, 6'h05);
        exp_q = '{8'h12, 8'hAA, 8'hCC};
        collect_frame(0);
        compare_frame("f034");
        check("f034_fc", {16'd0, frame_count}, 32'd2);

        // Empty keep: header only, carrying tlast
        drive_word(1, 48'h123456789ABC, 6'h00);
        check("f035_hdr_last", {31'd0, m_axis_tlast}, 32'd1);
        exp_q = '{8'h10};
        collect_frame(0);
        compare_frame("f035");
        check("f035_idle", {31'd0, m_axis_tvalid}, 32'd0);
        check("f035_fc", {16'd0, frame_count}, 32'd3);

        // Both channels requesting continuously: alternating grants, one idle cycle apart
        s_axis_tdata  = {48'h1112_1314_1516, 48'h0102_0304_0506};
        s_axis_tkeep  = {6'h3F, 6'h3F};
        s_axis_tvalid = 2'b11;
        #1;
        check("f033_rdy0", {30'd0, s_axis_tready}, 32'd1);
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            collect_frame(0);
            check("f033_len", got.size(), 7);
            check("f033_hdr", {24'd0, got[0]}, (f % 2 == 0) ? 32'h06 : 32'h16);
            check("f033_gap", {31'd0, m_axis_tvalid}, 32'd0);
            if (f == 3) begin
                s_axis_tvalid = '0;
            end else begin
                check("f033_next_rdy", {30'd0, s_axis_tready}, (f % 2 == 0) ? 32'd2 : 32'd1);
                @(negedge clk);
                check("f033_one_idle", {31'd0, m_axis_tvalid}, 32'd1);
            end
        end
        check("f033_fc", {16'd0, frame_count}, 32'd7);

        // Reset in the middle of a channel-0 payload, with both channels requesting
        @(negedge clk);
        d = 48'hA5A4_A3A2_A1A0;
        drive_word(0, d, 6'h3F);
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("f037_in_payload", {31'd0, m_axis_tvalid}, 32'd1);
        reset         = 1'b1;
        s_axis_tvalid = 2'b11;
        #1;
        check("f037_rst_rdy", {30'd0, s_axis_tready}, 32'd0);
        @(negedge clk);
        check("f037_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("f037_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("f037_fc", {16'd0, frame_count}, 32'd0);
        reset = 1'b0;
        #1;
        check("f037_ch0_first", {30'd0, s_axis_tready}, 32'd1);
        @(negedge clk);
        s_axis_tvalid = '0;
        check("f037_hdr", {24'd0, m_axis_tdata}, 32'h06);
        build_expected(0, d, 6'h3F);
        collect_frame(0);
        compare_frame("f037_frame");
        check("f037_fc_after", {16'd0, frame_count}, 32'd1);

        // 1000 random frames under random output backpressure
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            ch = int'($urandom_range(0, 1));
            d  = {16'($urandom), $urandom};
            k  = 6'($urandom_range(0, 63));
            drive_word(ch, d, k);
            build_expected(ch, d, k);
            collect_frame(1);
            compare_frame("rand");
        end
        check("rand_fc", {16'd0, frame_count}, 32'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
